// File: rtl/mem.sv
// Simple dual-port RAM: one always-on write port, one registered read port.
// Reads return old data on an address collision; array has no reset.
module mem #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 256,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [AW-1:0]    read_addr,
  output logic [WIDTH-1:0] read_data
);

  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];

  logic wr_ok;
  logic rd_ok;

  // Range checks only bite when DEPTH is not a power of two.
  always_comb begin
    wr_ok = ({1'b0, write_addr} < LIMIT);
    rd_ok = ({1'b0, read_addr} < LIMIT);
  end

  // Array write; no reset so the storage maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      ram[write_addr] <= write_data;
    end
  end

  // Registered read sampling the pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (rd_ok) begin
      read_data <= ram[read_addr];
    end else begin
      read_data <= '0;
    end
  end

endmodule

// File: tb/tb_mem.sv
// Bench for mem: directed vectors, a word-level reference model
// and a per-cycle compare of read_data against that model.
module tb_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  write_addr;
  logic [31:0] write_data;
  logic [7:0]  read_addr;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;

  mem #(32, 256) dut (
    .clk        (clk),
    .rst        (rst),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr  (read_addr),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  // Reference model: what the RAM holds and what the read port must show.
  logic [31:0] store [256];
  bit          known [256];
  logic [31:0] exp_v = '0;
  bit          exp_ok = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_v  = '0;
      exp_ok = 1'b1;
    end else begin
      exp_ok = known[read_addr];
      exp_v  = store[read_addr];
      store[write_addr] = write_data;
      known[write_addr] = 1'b1;
    end
  end

  always @(posedge rst) begin
    exp_v  = '0;
    exp_ok = 1'b1;
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (read_data !== 32'h0) begin
        errors++;
        $display("FAIL cyc_rst: read_data=%h required=00000000", read_data);
      end
    end else if (exp_ok) begin
      checks++;
      if (read_data !== exp_v) begin
        errors++;
        $display("FAIL cyc_model: read_data=%h required=%h", read_data, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] req);
    checks++;
    if (read_data !== req) begin
      errors++;
      $display("FAIL %s: read_data=%h required=%h", name, read_data, req);
    end
  endtask

  task automatic cyc(input logic [7:0] wa, input logic [31:0] wd,
                     input logic [7:0] ra);
    write_addr = wa;
    write_data = wd;
    read_addr  = ra;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    write_addr = 8'd200;
    write_data = '0;
    read_addr  = 8'd200;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_value", 32'h0);
    rst = 1'b0;

    cyc(8'd4, 32'd42, 8'd200);
    cyc(8'd200, 32'd0, 8'd4);
    chk("wr_then_rd", 32'd42);
    cyc(8'd4, 32'd31, 8'd4);
    chk("collide_old", 32'd42);
    cyc(8'd4, 32'd31, 8'd4);
    chk("collide_new", 32'd31);

    cyc(8'd20, 32'd42, 8'd20);
    checks++;
    if (read_data === 32'd42) begin
      errors++;
      $display("FAIL fresh_collide: read_data=%h required=not 0000002a",
               read_data);
    end
    cyc(8'd20, 32'd42, 8'd20);
    chk("fresh_held", 32'd42);

    cyc(8'd8, 32'd33, 8'd200);
    cyc(8'd12, 32'd99, 8'd200);
    cyc(8'd16, 32'd66, 8'd12);
    chk("rd12", 32'd99);
    cyc(8'd200, 32'd0, 8'd16);
    chk("rd16", 32'd66);
    cyc(8'd200, 32'd0, 8'd8);
    chk("rd8", 32'd33);

    #1 rst = 1'b1;
    #1 chk("async_rst", 32'h0);
    cyc(8'd8, 32'd77, 8'd4);
    chk("rst_hold", 32'h0);
    rst = 1'b0;
    cyc(8'd200, 32'd0, 8'd8);
    chk("rst_keep8", 32'd33);
    cyc(8'd200, 32'd0, 8'd4);
    chk("rst_keep4", 32'd31);

    cyc(8'd255, 32'd1, 8'd200);
    cyc(8'd255, 32'd2, 8'd200);
    cyc(8'd255, 32'd3, 8'd200);
    cyc(8'd200, 32'd0, 8'd255);
    chk("last_wins", 32'd3);

    cyc(8'd0, 32'hFFFF_FFFF, 8'd200);
    cyc(8'd255, 32'hA5A5_A5A5, 8'd200);
    cyc(8'd200, 32'd0, 8'd0);
    chk("addr0", 32'hFFFF_FFFF);
    cyc(8'd200, 32'd0, 8'd255);
    chk("addr255", 32'hA5A5_A5A5);

    for (int i = 0; i < 60; i++) begin
      cyc(8'($urandom_range(0, 15)), $urandom, 8'($urandom_range(0, 15)));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem.md
Name: mem

Overview:
- Parameterised single-clock simple dual-port RAM: one write port, one read port.
- The write port has no enable; it writes on every clock edge.
- The read port is registered with one cycle of latency and read-before-write (old-data) semantics.
- Used as a generic storage primitive inside datapaths and testbenches.

Parameters:
- WIDTH, 32, data word width in bits (first positional parameter).
- DEPTH, 256, number of words (second positional parameter). Address width AW = $clog2(DEPTH), which is 8 by default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_addr  input  AW  write word address.
- write_data  input  WIDTH  word written to mem[write_addr] on every rising edge.
- read_addr  input  AW  read word address, sampled on the rising edge.
- read_data  output  WIDTH  registered read result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Storage: array of DEPTH words of WIDTH bits.
  - Contents are NOT cleared by reset.
  - Never-written locations read as undefined (X in simulation).
- Reset value: read_data = 0, applied immediately when rst asserts, independent of clk.
- While rst is high:
  - no array write occurs;
  - read_data holds 0.
- Write, on each rising clk edge with rst low:
  - mem[write_addr] <= write_data unconditionally;
  - there is no write enable, so the caller must keep write_addr/write_data pointed at a harmless location when not intending to write.
- Read, on each rising clk edge with rst low:
  - read_data <= mem[read_addr];
  - latency is 1 cycle from address presentation to valid data.
  - read_data is held stable between edges.
- Read/write collision (read_addr == write_addr on the same edge):
  - read_data returns the OLD contents;
  - the new data is visible on the following edge if read_addr is held.
- Write followed by read:
  - data written at edge N is readable by a read sampled at edge N+1 or later;
  - it appears on read_data after edge N+1.
- Consecutive writes to the same address: last write wins.
- Out-of-range addresses (only possible when DEPTH is not a power of two):
  - writes with address >= DEPTH are ignored;
  - reads with address >= DEPTH return 0.
- Reset mid-operation:
  - read_data goes to 0 immediately;
  - array contents written before reset are retained and readable after rst deasserts;
  - a write coinciding with reset assertion is dropped.
- Synthesis: the array must infer block RAM where available, so there is no reset on the array and the read is registered.

Test Plan:
- Reset then write 42 to addr 4; next edge read_addr=4 -> read_data=42 after that edge. Then write_data=31 (still addr 4) with read_addr=4: the first edge returns 42, the second edge returns 31.
- Simultaneous write 42 and read at addr 20, never previously written: the first edge returns old/undefined (X) data, not 42; the second edge (same inputs held) returns 42.
- Write 8<-33, 12<-99, then write 16<-66 while reading 12:
  - read 12 -> 99;
  - next edge read 16 -> 66;
  - next edge read 8 -> 33.
- Assert rst asynchronously between edges while read_data is nonzero:
  - read_data drops to 0 immediately;
  - after deassert, reading a previously written address returns the stored value one edge later.
- Back-to-back writes 1, 2, 3 to addr 255 (top address), then read 255 -> 3.
- Address 0 and address DEPTH-1 written with distinct patterns (all-ones and 0xA5A5A5A5) -> each reads back unaltered, with no aliasing.
